mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage of the RV64 core, between the EX/MEM register and mem_wb.
//  Issues loads/stores on a single-outstanding req/ack data bus; aligns/extends loads and
//  positions store data with byte enables. Raises stall_req_o while an access is pending.
//  Non-memory instructions pass through combinationally.
// PARAMETERS
//  XLEN      64   datapath/address width; only 64 is supported
//  MAX_WAIT  255  bus watchdog limit in cycles (counter width = $clog2(MAX_WAIT+1))
// PORTS
//  clk                 in   1   clock, rising edge
//  rst                 in   1   synchronous reset, active-low (0 = reset)
//  alu_result_i        in   64  EX result; effective address for memory ops
//  reg_write_addr_i    in   5   destination register
//  reg_write_enable_i  in   1   destination write enable
//  mem_read_i          in   1   load instruction
//  mem_write_i         in   1   store instruction
//  mem_funct3_i        in   3   RV funct3 (size/sign)
//  store_data_i        in   64  rs2 value for stores
//  result_o            out  64  to mem_wb result_i
//  reg_write_addr_o    out  5   to mem_wb
//  reg_write_enable_o  out  1   to mem_wb
//  stall_req_o         out  1   hold upstream stages; drives mem_wb stall
//  bus_req_o           out  1   access request, registered
//  bus_we_o            out  1   1 = write
//  bus_addr_o          out  64  doubleword-aligned address {addr[63:3],3'b0}
//  bus_wdata_o         out  64  lane-positioned store data
//  bus_be_o            out  8   byte enables
//  bus_ack_i           in   1   one-cycle completion; bus_rdata_i valid in that cycle
//  bus_rdata_i         in   64  read data
//  bus_err_o           out  1   one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  - FSM IDLE -> WAIT -> DONE -> IDLE. All bus_* outputs and bus_err_o are registers.
//  - IDLE, no mem op: result_o=alu_result_i, addr/enable pass through, stall_req_o=0.
//  - IDLE, mem op: stall_req_o=1 (comb.); next edge load bus_* regs, bus_req_o=1, enter WAIT.
//  - WAIT: stall_req_o=1; bus_* held stable; watchdog counts up from 0 each cycle.
//    bus_ack_i=1 -> capture rdata into load_buf; bus_req_o=0; enter DONE.
//    count==MAX_WAIT without ack -> bus_req_o=0, bus_err_o=1 for one cycle, err flag set,
//    enter DONE.
//  - DONE: stall_req_o=0 for exactly one cycle; upstream advances at this edge.
//    Load: result_o=extended load_buf. Store: result_o=0, reg_write_enable_o=0.
//    Err flag: result_o=0, reg_write_enable_o=0. Then IDLE.
//  - Load latency = ack cycle + 1 (min 3 cycles from presentation with zero-wait ack).
//  - Loads, off=addr[2:0]: LB/LBU byte, LH/LHU half, LW/LWU word, LD dword taken at
//    bit off*8; LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; funct3 111 -> result 0.
//  - Stores: SB/SH/SW/SD mask 1/3/F/FF shifted left by off, truncated to 8 bits;
//    wdata = store_data_i << (off*8). Store funct3 >= 100 -> be=0 (bus no-op, still acked).
//  - mem_read_i and mem_write_i both 1: treated as a load.
//  - bus_ack_i outside WAIT: ignored.
//  - rst=0 at any state: next edge -> IDLE, bus_req_o=0, bus_we_o=0, bus_addr_o=0,
//    bus_wdata_o=0, bus_be_o=0, bus_err_o=0, counter=0, load_buf=0.
//    While rst=0: stall_req_o=0, reg_write_enable_o=0, result_o=0.
//    Ack of an abandoned access arriving after reset is ignored.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: adds ports misalign_o (out,1) and misalign_addr_o
//    (out,64). Access with addr not a multiple of its size: no bus request; enters DONE
//    directly; misalign_o=1 and misalign_addr_o=addr for that DONE cycle;
//    reg_write_enable_o=0.
//  Not defined: ports absent. Misaligned accesses issue as-is. Bytes beyond the
//    doubleword boundary are dropped (be truncated; load returns the in-lane bytes,
//    upper bits extended per funct3).
// STRUCTURE
//  mem_pkg: funct3 constants (F3_B..F3_WU), state enum mem_state_t, size-mask function.
//  Sub-module mem_load_align: combinational lane select + sign/zero extension.
// TESTING
//  1 ADD, alu_result_i=0x1234, rd=5 -> same cycle result_o=0x1234, stall_req_o=0, no bus_req.
//  2 LB addr=0x1003, rdata=0x00000000_80000000, ack 2 cycles after req ->
//    bus_addr_o=0x1000; result_o=0xFFFF...FF80; stall 4 cycles.
//  3 SH addr=0x2006, data=0xABCD -> be=0xC0, wdata=0xABCD0000_00000000,
//    reg_write_enable_o=0 in DONE.
//  4 LD with no ack, MAX_WAIT=4 -> req drops after 4 wait cycles; bus_err_o 1 cycle; no write.
//  5 rst=0 during WAIT, then late ack -> bus_req_o=0 next edge; ack ignored; FSM in IDLE.
//  6 With MEM_MISALIGN_TRAP_EN: LW addr=0x3002 -> no bus_req; misalign_o=1,
//    misalign_addr_o=0x3002.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the RV64 MEM stage: funct3 codes, FSM states and lane masks.
// Used by mem_stage (optional MEM_MISALIGN_TRAP_EN build) and mem_load_align.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mem_state_t;

    // Byte-lane mask for an access of 2**size bytes starting at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed lane of a doubleword and sign/zero-extends it.
// Lanes beyond the doubleword boundary read as zero before extension.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] result_o
);

    logic [63:0] lane;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        lane     = rdata_i >> {offset_i, 3'b000};
        result_o = '0;
        case (funct3_i)
            F3_B:    result_o = {{56{lane[7]}}, lane[7:0]};
            F3_H:    result_o = {{48{lane[15]}}, lane[15:0]};
            F3_W:    result_o = {{32{lane[31]}}, lane[31:0]};
            F3_D:    result_o = lane;
            F3_BU:   result_o = {56'd0, lane[7:0]};
            F3_HU:   result_o = {48'd0, lane[15:0]};
            F3_WU:   result_o = {32'd0, lane[31:0]};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV64 MEM stage: single-outstanding req/ack bus master with a watchdog, load alignment
// and store lane positioning. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [4:0]      reg_write_addr_i,
    input  logic            reg_write_enable_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      reg_write_addr_o,
    output logic            reg_write_enable_o,
    output logic            stall_req_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    output logic [7:0]      bus_be_o,
    input  logic            bus_ack_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    output logic            bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
`endif
);

    localparam int            CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    mem_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] load_buf_q, load_buf_d;
    logic            err_q, err_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic [7:0]      bus_be_q, bus_be_d;
    logic            bus_err_q, bus_err_d;
    logic            mem_op;
    logic [2:0]      off;
    logic [XLEN-1:0] load_result;

    assign mem_op = mem_read_i | mem_write_i;
    assign off    = alu_result_i[2:0];

`ifdef MEM_MISALIGN_TRAP_EN
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;
    logic [2:0]      align_mask;
    logic            misaligned;

    // Low address bits that must be zero for a 1/2/4/8-byte access.
    assign align_mask = {&mem_funct3_i[1:0], mem_funct3_i[1], |mem_funct3_i[1:0]};
    assign misaligned = |(off & align_mask);
    assign misalign_o      = mis_q;
    assign misalign_addr_o = mis_addr_q;
`endif

    mem_load_align u_load_align (
        .rdata_i  (load_buf_q),
        .offset_i (off),
        .funct3_i (mem_funct3_i),
        .result_o (load_result)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_buf_d  = load_buf_q;
        err_d       = err_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_err_d   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d       = mis_q;
        mis_addr_d  = mis_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    err_d = 1'b0;
                    cnt_d = '0;
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        mis_d      = 1'b1;
                        mis_addr_d = alu_result_i;
                        state_d    = S_DONE;
                    end else begin
`else
                    begin
`endif
                        state_d     = S_WAIT;
                        bus_req_d   = 1'b1;
                        bus_we_d    = ~mem_read_i;
                        bus_addr_d  = {alu_result_i[XLEN-1:3], 3'b000};
                        bus_wdata_d = mem_read_i ? '0 : store_data_i << {off, 3'b000};
                        // Store funct3 codes 100..111 are not stores: issue with no lanes enabled.
                        bus_be_d    = (!mem_read_i && mem_funct3_i[2]) ? 8'h00
                                    : size_mask(mem_funct3_i[1:0]) << off;
                    end
                end
            end
            S_WAIT: begin
                if (bus_ack_i) begin
                    load_buf_d = bus_rdata_i;
                    bus_req_d  = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_MAX) begin
                        bus_req_d = 1'b0;
                        bus_err_d = 1'b1;
                        err_d     = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                mis_d   = 1'b0;
`endif
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            load_buf_q  <= '0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            bus_err_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
            mis_addr_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_buf_q  <= load_buf_d;
            err_q       <= err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_err_q   <= bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q       <= mis_d;
            mis_addr_q  <= mis_addr_d;
`endif
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_be_o    = bus_be_q;
    assign bus_err_o   = bus_err_q;

    // Upstream inputs are held by stall_req_o, so DONE still sees the originating instruction.
    always_comb begin
        result_o           = alu_result_i;
        reg_write_addr_o   = reg_write_addr_i;
        reg_write_enable_o = reg_write_enable_i;
        stall_req_o        = 1'b0;
        if (!rst) begin
            result_o           = '0;
            reg_write_enable_o = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: stall_req_o = mem_op;
                S_WAIT: stall_req_o = 1'b1;
                default: begin
`ifdef MEM_MISALIGN_TRAP_EN
                    if (err_q || mis_q || !mem_read_i) begin
`else
                    if (err_q || !mem_read_i) begin
`endif
                        result_o           = '0;
                        reg_write_enable_o = 1'b0;
                    end else begin
                        result_o = load_result;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage (default build, MAX_WAIT=4) with a byte-level
// reference model for load extraction and store lane placement.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] alu_result_i;
    logic [4:0]  reg_write_addr_i;
    logic        reg_write_enable_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  mem_funct3_i;
    logic [63:0] store_data_i;
    logic [63:0] result_o;
    logic [4:0]  reg_write_addr_o;
    logic        reg_write_enable_o;
    logic        stall_req_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [63:0] bus_addr_o;
    logic [63:0] bus_wdata_o;
    logic [7:0]  bus_be_o;
    logic        bus_ack_i;
    logic [63:0] bus_rdata_i;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(64), .MAX_WAIT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .alu_result_i       (alu_result_i),
        .reg_write_addr_i   (reg_write_addr_i),
        .reg_write_enable_i (reg_write_enable_i),
        .mem_read_i         (mem_read_i),
        .mem_write_i        (mem_write_i),
        .mem_funct3_i       (mem_funct3_i),
        .store_data_i       (store_data_i),
        .result_o           (result_o),
        .reg_write_addr_o   (reg_write_addr_o),
        .reg_write_enable_o (reg_write_enable_o),
        .stall_req_o        (stall_req_o),
        .bus_req_o          (bus_req_o),
        .bus_we_o           (bus_we_o),
        .bus_addr_o         (bus_addr_o),
        .bus_wdata_o        (bus_wdata_o),
        .bus_be_o           (bus_be_o),
        .bus_ack_i          (bus_ack_i),
        .bus_rdata_i        (bus_rdata_i),
        .bus_err_o          (bus_err_o)
    );

    // Reference model: bytes of the addressed access, extended by funct3.
    function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                               input logic [2:0] f3);
        int size;
        logic [63:0] v;
        if (f3 == 3'b111) return 64'd0;
        size = 1 << f3[1:0];
        v = 64'd0;
        for (int k = 0; k < size; k++)
            if (off + k < 8) v[8*k +: 8] = rdata[8*(off+k) +: 8];
        if (!f3[2] && size < 8 && v[8*size-1])
            for (int k = size; k < 8; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] model_be(input int off, input logic [2:0] f3);
        logic [7:0] be;
        int size;
        be = 8'h00;
        size = 1 << f3[1:0];
        if (!f3[2])
            for (int i = 0; i < 8; i++) be[i] = (i >= off) && (i < off + size);
        return be;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] sd, input int off);
        logic [63:0] w;
        w = 64'd0;
        for (int i = 0; i < 8; i++)
            if (i >= off) w[8*i +: 8] = sd[8*(i-off) +: 8];
        return w;
    endfunction

    task automatic drive_nop();
        mem_read_i         = 1'b0;
        mem_write_i        = 1'b0;
        mem_funct3_i       = 3'($urandom_range(0, 7));
        alu_result_i       = {$urandom, $urandom};
        reg_write_addr_i   = 5'($urandom_range(0, 31));
        reg_write_enable_i = 1'b1;
        store_data_i       = {$urandom, $urandom};
        bus_ack_i          = 1'b0;
        bus_rdata_i        = {$urandom, $urandom};
    endtask

    // One memory instruction from presentation through DONE; data is rdata for loads, rs2 for stores.
    task automatic run_access(input bit is_load, input bit both, input logic [63:0] addr,
                              input logic [2:0] f3, input logic [63:0] data,
                              input int ack_wait, input logic [4:0] rd);
        int off;
        int stalls;
        logic [63:0] exp_res;
        off = int'(addr[2:0]);
        exp_res = is_load ? model_load(data, off, f3) : 64'd0;
        @(negedge clk);
        alu_result_i       = addr;
        mem_read_i         = is_load;
        mem_write_i        = !is_load || both;
        mem_funct3_i       = f3;
        store_data_i       = is_load ? {$urandom, $urandom} : data;
        reg_write_addr_i   = rd;
        reg_write_enable_i = 1'b1;
        bus_ack_i          = 1'b0;
        #1;
        checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL present_stall addr=%h: got %b exp 1", addr, stall_req_o); end
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL present_req addr=%h: got %b exp 0", addr, bus_req_o); end
        stalls = 1;
        for (int c = 0; c <= ack_wait; c++) begin
            @(negedge clk);
            bus_ack_i   = (c == ack_wait);
            bus_rdata_i = (c == ack_wait && is_load) ? data : {$urandom, $urandom};
            #1;
            if (stall_req_o) stalls++;
            checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL wait_req addr=%h c=%0d: got %b exp 1", addr, c, bus_req_o); end
            checks++; if (bus_addr_o !== {addr[63:3], 3'b000}) begin errors++; $display("FAIL bus_addr: got %h exp %h", bus_addr_o, {addr[63:3], 3'b000}); end
            checks++; if (bus_we_o !== !is_load) begin errors++; $display("FAIL bus_we addr=%h: got %b exp %b", addr, bus_we_o, !is_load); end
            if (!is_load) begin
                checks++; if (bus_be_o !== model_be(off, f3)) begin errors++; $display("FAIL bus_be addr=%h f3=%0d: got %h exp %h", addr, f3, bus_be_o, model_be(off, f3)); end
                checks++; if (bus_wdata_o !== model_wdata(data, off)) begin errors++; $display("FAIL bus_wdata addr=%h: got %h exp %h", addr, bus_wdata_o, model_wdata(data, off)); end
            end
        end
        @(negedge clk);
        bus_ack_i = 1'b0;
        #1;
        checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL done_stall addr=%h: got %b exp 0", addr, stall_req_o); end
        checks++; if (result_o !== exp_res) begin errors++; $display("FAIL done_result addr=%h f3=%0d: got %h exp %h", addr, f3, result_o, exp_res); end
        checks++; if (reg_write_enable_o !== is_load) begin errors++; $display("FAIL done_we addr=%h: got %b exp %b", addr, reg_write_enable_o, is_load); end
        checks++; if (reg_write_addr_o !== rd) begin errors++; $display("FAIL done_rd: got %0d exp %0d", reg_write_addr_o, rd); end
        checks++; if (bus_req_o !== 1'b0 || bus_err_o !== 1'b0) begin errors++; $display("FAIL done_bus: got req=%b err=%b exp 0 0", bus_req_o, bus_err_o); end
        checks++; if (stalls !== ack_wait + 2) begin errors++; $display("FAIL stall_cycles addr=%h: got %0d exp %0d", addr, stalls, ack_wait + 2); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_nop();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0 || bus_err_o !== 1'b0) begin errors++; $display("FAIL reset_bus_ctrl: got req=%b we=%b err=%b exp 0 0 0", bus_req_o, bus_we_o, bus_err_o); end
        checks++; if (bus_addr_o !== 64'd0 || bus_wdata_o !== 64'd0 || bus_be_o !== 8'd0) begin errors++; $display("FAIL reset_bus_data: got addr=%h wdata=%h be=%h exp 0", bus_addr_o, bus_wdata_o, bus_be_o); end
        checks++; if (stall_req_o !== 1'b0 || reg_write_enable_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL reset_out: got stall=%b we=%b result=%h exp 0 0 0", stall_req_o, reg_write_enable_o, result_o); end
        rst = 1'b1;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_nop();
            if (i == 0) begin
                alu_result_i     = 64'h1234;
                reg_write_addr_i = 5'd5;
            end
            reg_write_enable_i = 1'($urandom_range(0, 1));
            bus_ack_i          = 1'($urandom_range(0, 1));
            #1;
            checks++; if (result_o !== alu_result_i) begin errors++; $display("FAIL pass_result: got %h exp %h", result_o, alu_result_i); end
            checks++; if (reg_write_addr_o !== reg_write_addr_i || reg_write_enable_o !== reg_write_enable_i) begin errors++; $display("FAIL pass_rd: got %0d/%b exp %0d/%b", reg_write_addr_o, reg_write_enable_o, reg_write_addr_i, reg_write_enable_i); end
            checks++; if (stall_req_o !== 1'b0 || bus_req_o !== 1'b0) begin errors++; $display("FAIL pass_ctrl: got stall=%b req=%b exp 0 0", stall_req_o, bus_req_o); end
        end
        @(negedge clk);
        drive_nop();
    endtask

    task automatic test_directed();
        run_access(1'b1, 1'b0, 64'h1003, 3'b000, 64'h00000000_80000000, 2, 5'd7);
        run_access(1'b0, 1'b0, 64'h2006, 3'b001, 64'h0000_0000_0000_ABCD, 1, 5'd3);
        run_access(1'b1, 1'b0, 64'h0000_0000_0000_3008, 3'b011, 64'hDEAD_BEEF_0123_4567, 0, 5'd1);
        run_access(1'b1, 1'b0, 64'h3004, 3'b110, 64'h8765_4321_0000_0000, 3, 5'd2);
        run_access(1'b1, 1'b0, 64'h3006, 3'b001, 64'h8001_0000_0000_0000, 1, 5'd4);
        run_access(1'b1, 1'b0, 64'h3000, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 0, 5'd6);
        run_access(1'b0, 1'b0, 64'h2003, 3'b100, 64'h1122_3344_5566_7788, 0, 5'd8);
        run_access(1'b0, 1'b0, 64'h2005, 3'b010, 64'h0000_0000_CAFE_F00D, 2, 5'd9);
        run_access(1'b1, 1'b1, 64'h4002, 3'b101, 64'h0000_0000_F00D_0000, 1, 5'd10);
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clk);
        drive_nop();
        alu_result_i     = 64'h4000;
        mem_read_i       = 1'b1;
        mem_funct3_i     = 3'b011;
        reg_write_addr_i = 5'd9;
        #1;
        checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL to_present_stall: got %b exp 1", stall_req_o); end
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (!bus_req_o) break;
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d exp 4", n); end
        checks++; if (bus_err_o !== 1'b1 || stall_req_o !== 1'b0) begin errors++; $display("FAIL to_done: got err=%b stall=%b exp 1 0", bus_err_o, stall_req_o); end
        checks++; if (reg_write_enable_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL to_nowrite: got we=%b result=%h exp 0 0", reg_write_enable_o, result_o); end
        @(negedge clk);
        drive_nop();
        #1;
        checks++; if (bus_err_o !== 1'b0 || bus_req_o !== 1'b0 || stall_req_o !== 1'b0) begin errors++; $display("FAIL to_after: got err=%b req=%b stall=%b exp 0 0 0", bus_err_o, bus_req_o, stall_req_o); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        drive_nop();
        alu_result_i = 64'h5008;
        mem_write_i  = 1'b1;
        mem_funct3_i = 3'b011;
        store_data_i = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        #1;
        checks++; if (bus_req_o !== 1'b1 || bus_wdata_o !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL rw_wait: got req=%b wdata=%h exp 1 0123456789abcdef", bus_req_o, bus_wdata_o); end
        rst = 1'b0;
        #1;
        checks++; if (stall_req_o !== 1'b0 || reg_write_enable_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL rw_rst_comb: got stall=%b we=%b result=%h exp 0 0 0", stall_req_o, reg_write_enable_o, result_o); end
        @(negedge clk);
        #1;
        checks++; if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0 || bus_be_o !== 8'd0 || bus_wdata_o !== 64'd0 || bus_addr_o !== 64'd0) begin errors++; $display("FAIL rw_rst_regs: got req=%b we=%b be=%h wdata=%h addr=%h exp all 0", bus_req_o, bus_we_o, bus_be_o, bus_wdata_o, bus_addr_o); end
        rst = 1'b1;
        drive_nop();
        bus_ack_i = 1'b1;
        #1;
        checks++; if (stall_req_o !== 1'b0 || result_o !== alu_result_i) begin errors++; $display("FAIL rw_idle: got stall=%b result=%h exp 0 %h", stall_req_o, result_o, alu_result_i); end
        @(negedge clk);
        bus_ack_i = 1'b0;
        #1;
        checks++; if (bus_req_o !== 1'b0 || bus_err_o !== 1'b0 || stall_req_o !== 1'b0) begin errors++; $display("FAIL rw_late_ack: got req=%b err=%b stall=%b exp 0 0 0", bus_req_o, bus_err_o, stall_req_o); end
    endtask

    task automatic test_random();
        int kind;
        int size;
        logic [2:0] f3;
        logic [63:0] addr;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            f3   = 3'($urandom_range(0, 7));
            addr = {$urandom, $urandom};
            if (kind == 0) begin
                @(negedge clk);
                drive_nop();
                #1;
                checks++; if (result_o !== alu_result_i || stall_req_o !== 1'b0) begin errors++; $display("FAIL rnd_nop: got result=%h stall=%b exp %h 0", result_o, stall_req_o, alu_result_i); end
            end else if (kind == 1) begin
                size = 1 << f3[1:0];
                addr[2:0] = 3'($urandom_range(0, 7) & ~(size - 1));
                run_access(1'b1, 1'b0, addr, f3, {$urandom, $urandom}, $urandom_range(0, 3), 5'($urandom_range(0, 31)));
            end else begin
                run_access(1'b0, 1'b0, addr, f3, {$urandom, $urandom}, $urandom_range(0, 3), 5'($urandom_range(0, 31)));
            end
        end
        @(negedge clk);
        drive_nop();
    endtask

    initial begin
        rst = 1'b0;
        drive_nop();
        test_reset();
        test_passthrough();
        test_directed();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
